// File: rtl/reorder_logic_pkg.sv
// Shared definitions for the re-order trace dispatcher: width helper, default sizing and FSM states.
// Imported by the interface, the ID allocator and the dispatcher top.
package reorder_logic_pkg;

  // Returns the number of bits needed to index 'value' items. The result is never less than 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  localparam int DEF_NUM_QUEUES = 4;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_MAX_OPS    = 8;
  localparam int DEF_SEL_WIDTH  = clog2(DEF_NUM_QUEUES);
  localparam int DEF_ID_WIDTH   = clog2(DEF_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } dispatch_state_e;

endpackage

// File: rtl/reorder_trace_dispatcher_if.sv
// Bundle of the upstream request, re-order trace, commit drain and retirement signals.
// The master modport is the dispatcher's view; the slave modport is its environment's view.
interface reorder_trace_dispatcher_if
  import reorder_logic_pkg::*;
#(
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int ID_WIDTH  = DEF_ID_WIDTH
);

  logic                 req_valid;
  logic                 req_ready;
  logic [SEL_WIDTH-1:0] req_sel;
  logic                 req_last;
  logic                 req_abort;
  logic                 full;
  logic                 trace_id_push;
  logic [ID_WIDTH-1:0]  trace_id_value;
  logic                 trace_push;
  logic [SEL_WIDTH-1:0] trace_sel;
  logic                 trace_break;
  logic                 trace_update;
  logic                 commit_id_valid;
  logic [ID_WIDTH-1:0]  commit_id_value;
  logic                 commit_id_pull;
  logic                 retire_valid;
  logic [ID_WIDTH-1:0]  retire_id;
  logic                 err;

  modport master (
    input  req_valid, req_sel, req_last, req_abort, full, commit_id_valid, commit_id_value,
    output req_ready, trace_id_push, trace_id_value, trace_push, trace_sel, trace_break,
           trace_update, commit_id_pull, retire_valid, retire_id, err
  );

  modport slave (
    output req_valid, req_sel, req_last, req_abort, full, commit_id_valid, commit_id_value,
    input  req_ready, trace_id_push, trace_id_value, trace_push, trace_sel, trace_break,
           trace_update, commit_id_pull, retire_valid, retire_id, err
  );

endinterface

// File: rtl/reorder_id_allocator.sv
// In-order transaction ID pool: allocation pointer, retirement pointer and in-flight counter.
// Back-pressures allocation once DEPTH transactions are outstanding.
module reorder_id_allocator
  import reorder_logic_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ID_WIDTH = clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                alloc,
  input  logic                retire,
  output logic [ID_WIDTH-1:0] next_id,
  output logic [ID_WIDTH-1:0] expected_id,
  output logic                can_alloc
);

  localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(DEPTH - 1);
  localparam logic [ID_WIDTH-1:0] ID_ONE   = ID_WIDTH'(1);
  localparam logic [ID_WIDTH:0]   CNT_FULL = (ID_WIDTH + 1)'(DEPTH);
  localparam logic [ID_WIDTH:0]   CNT_ONE  = (ID_WIDTH + 1)'(1);

  logic [ID_WIDTH-1:0] alloc_ptr;
  logic [ID_WIDTH-1:0] retire_ptr;
  logic [ID_WIDTH:0]   inflight;

  // Pointers wrap explicitly so a non-power-of-two DEPTH still cycles through 0..DEPTH-1.
  function automatic logic [ID_WIDTH-1:0] bump(input logic [ID_WIDTH-1:0] ptr);
    return (ptr == LAST_ID) ? '0 : ptr + ID_ONE;
  endfunction

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      alloc_ptr  <= '0;
      retire_ptr <= '0;
      inflight   <= '0;
    end else begin
      if (alloc) begin
        alloc_ptr <= bump(alloc_ptr);
      end
      if (retire) begin
        retire_ptr <= bump(retire_ptr);
      end
      // A commit with nothing in flight is illegal; the count saturates rather than underflowing.
      if (alloc && !retire) begin
        inflight <= inflight + CNT_ONE;
      end else if (retire && !alloc && (inflight != '0)) begin
        inflight <= inflight - CNT_ONE;
      end
    end
  end

  assign next_id     = alloc_ptr;
  assign expected_id = retire_ptr;
  assign can_alloc   = (inflight < CNT_FULL);

endmodule

// File: rtl/reorder_trace_dispatcher.sv
// Initiator side of the re-order engine: groups upstream ops into transactions, pushes trace traffic and retires IDs.
// Optional DISPATCH_ID_CHECK_EN adds a sticky err flag for commits that arrive out of order.
module reorder_trace_dispatcher
  import reorder_logic_pkg::*;
#(
  parameter int   NUM_QUEUES = DEF_NUM_QUEUES,
  parameter int   DEPTH      = DEF_DEPTH,
  parameter logic BREAKPOINT = 1'b1,
  parameter int   MAX_OPS    = DEF_MAX_OPS
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  reorder_trace_dispatcher_if.master bus
);

  localparam int SEL_WIDTH = clog2(NUM_QUEUES);
  localparam int ID_WIDTH  = clog2(DEPTH);
  localparam int CNT_WIDTH = clog2(MAX_OPS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OPS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  dispatch_state_e      state_q;
  dispatch_state_e      state_d;
  logic [CNT_WIDTH-1:0] op_cnt_q;
  logic [CNT_WIDTH-1:0] op_cnt_d;
  logic [CNT_WIDTH-1:0] op_cnt_inc;
  logic [ID_WIDTH-1:0]  next_id;
  logic [ID_WIDTH-1:0]  expected_id;
  logic                 can_alloc;
  logic                 alloc;
  logic                 retire;
  logic                 accept;
  logic                 closes;
  logic                 id_push_d;
  logic                 push_d;
  logic                 break_d;
  logic                 update_d;

  reorder_id_allocator #(
    .DEPTH    (DEPTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_id_allocator (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .alloc       (alloc),
    .retire      (retire),
    .next_id     (next_id),
    .expected_id (expected_id),
    .can_alloc   (can_alloc)
  );

  // An open transaction already owns its ID, so only a new one needs pool space.
  assign bus.req_ready      = ~bus.full & ~bus.req_abort & ((state_q == ST_OPEN) | can_alloc);
  assign accept             = bus.req_valid & bus.req_ready;
  assign op_cnt_inc         = op_cnt_q + CNT_ONE;
  assign closes             = bus.req_last | (op_cnt_inc == CNT_MAX);
  assign bus.commit_id_pull = bus.commit_id_valid;
  assign retire             = bus.commit_id_valid;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_cnt_d  = op_cnt_q;
    alloc     = 1'b0;
    id_push_d = 1'b0;
    push_d    = 1'b0;
    break_d   = 1'b0;
    update_d  = 1'b0;
    // Abort drops req_ready, so it can never coincide with an accepted op.
    if ((state_q == ST_OPEN) && bus.req_abort) begin
      update_d = 1'b1;
      op_cnt_d = '0;
      state_d  = ST_IDLE;
    end else if (accept) begin
      push_d = 1'b1;
      if (state_q == ST_IDLE) begin
        alloc     = 1'b1;
        id_push_d = 1'b1;
      end
      if (closes) begin
        break_d  = BREAKPOINT;
        op_cnt_d = '0;
        state_d  = ST_IDLE;
      end else begin
        break_d  = ~BREAKPOINT;
        op_cnt_d = op_cnt_inc;
        state_d  = ST_OPEN;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      bus.trace_id_push  <= 1'b0;
      bus.trace_id_value <= '0;
      bus.trace_push     <= 1'b0;
      bus.trace_sel      <= '0;
      bus.trace_break    <= 1'b0;
      bus.trace_update   <= 1'b0;
      bus.retire_valid   <= 1'b0;
      bus.retire_id      <= '0;
    end else begin
      bus.trace_id_push <= id_push_d;
      bus.trace_push    <= push_d;
      bus.trace_break   <= break_d;
      bus.trace_update  <= update_d;
      bus.retire_valid  <= retire;
      if (id_push_d) begin
        bus.trace_id_value <= next_id;
      end
      if (push_d) begin
        bus.trace_sel <= SEL_WIDTH'(bus.req_sel);
      end
      if (retire) begin
        bus.retire_id <= bus.commit_id_value;
      end
    end
  end

`ifdef DISPATCH_ID_CHECK_EN
  // Commits must come back in allocation order; the flag latches the first violation.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      bus.err <= 1'b0;
    end else if (retire && (bus.commit_id_value != expected_id)) begin
      bus.err <= 1'b1;
    end
  end
`else
  logic unused_expected_id;
  assign unused_expected_id = ^expected_id;
  assign bus.err            = 1'b0;
`endif

endmodule

// File: tb/tb_reorder_trace_dispatcher.sv
// Self-checking bench for reorder_trace_dispatcher: directed scenarios plus randomized traffic
// compared against a transaction-level reference model (ID queue, open flag, op count).
module tb_reorder_trace_dispatcher;
  import reorder_logic_pkg::*;

  localparam int NUM_QUEUES = 4;
  localparam int DEPTH      = 64;
  localparam int MAX_OPS    = 8;
  localparam int SEL_W      = clog2(NUM_QUEUES);
  localparam int ID_W       = clog2(DEPTH);
`ifdef DISPATCH_ID_CHECK_EN
  localparam bit ID_CHECK = 1'b1;
`else
  localparam bit ID_CHECK = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;

  reorder_trace_dispatcher_if #(.SEL_WIDTH(SEL_W), .ID_WIDTH(ID_W)) bus ();

  reorder_trace_dispatcher #(
    .NUM_QUEUES (NUM_QUEUES),
    .DEPTH      (DEPTH),
    .BREAKPOINT (1'b1),
    .MAX_OPS    (MAX_OPS)
  ) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int cmp_count  = 0;
  int fail_count = 0;

  // Reference model: transaction view of the dispatcher
  bit m_open;
  int m_cnt;
  int m_next_id;
  int m_retire_ptr;
  bit m_err;
  int outstanding[$];

  // Registered outputs expected after the next clock edge
  bit e_idpush;
  int e_idval;
  bit e_push;
  int e_sel;
  bit e_break;
  bit e_update;
  bit e_rv;
  int e_rid;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    cmp_count++;
    if (observed != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic clearModel();
    m_open       = 1'b0;
    m_cnt        = 0;
    m_next_id    = 0;
    m_retire_ptr = 0;
    m_err        = 1'b0;
    outstanding.delete();
    e_idpush = 1'b0;
    e_idval  = 0;
    e_push   = 1'b0;
    e_sel    = 0;
    e_break  = 1'b0;
    e_update = 1'b0;
    e_rv     = 1'b0;
    e_rid    = 0;
  endtask

  task automatic driveIdleInputs();
    bus.req_valid       = 1'b0;
    bus.req_sel         = '0;
    bus.req_last        = 1'b0;
    bus.req_abort       = 1'b0;
    bus.full            = 1'b0;
    bus.commit_id_valid = 1'b0;
    bus.commit_id_value = '0;
  endtask

  task automatic checkRegistered();
    checkOutput("trace_id_push", int'(bus.trace_id_push), int'(e_idpush));
    if (e_idpush) checkOutput("trace_id_value", int'(bus.trace_id_value), e_idval);
    checkOutput("trace_push", int'(bus.trace_push), int'(e_push));
    if (e_push) begin
      checkOutput("trace_sel", int'(bus.trace_sel), e_sel);
      checkOutput("trace_break", int'(bus.trace_break), int'(e_break));
    end
    checkOutput("trace_update", int'(bus.trace_update), int'(e_update));
    checkOutput("retire_valid", int'(bus.retire_valid), int'(e_rv));
    if (e_rv) checkOutput("retire_id", int'(bus.retire_id), e_rid);
    checkOutput("err", int'(bus.err), int'(m_err));
  endtask

  task automatic resetDut();
    @(negedge clk_i);
    arst_i = 1'b1;
    driveIdleInputs();
    #1;
    checkOutput("rst_trace_id_push", int'(bus.trace_id_push), 0);
    checkOutput("rst_trace_id_value", int'(bus.trace_id_value), 0);
    checkOutput("rst_trace_push", int'(bus.trace_push), 0);
    checkOutput("rst_trace_sel", int'(bus.trace_sel), 0);
    checkOutput("rst_trace_break", int'(bus.trace_break), 0);
    checkOutput("rst_trace_update", int'(bus.trace_update), 0);
    checkOutput("rst_retire_valid", int'(bus.retire_valid), 0);
    checkOutput("rst_retire_id", int'(bus.retire_id), 0);
    checkOutput("rst_err", int'(bus.err), 0);
    checkOutput("rst_commit_pull", int'(bus.commit_id_pull), 0);
    @(negedge clk_i);
    arst_i = 1'b0;
    clearModel();
  endtask

  // One clock of stimulus: check last cycle's registered outputs, drive, check combinational outputs, advance model.
  task automatic applyStimulus(input bit v, input int sel, input bit last, input bit abort,
                               input bit full, input bit cv, input int cval);
    bit ready_exp;
    bit accept;
    @(negedge clk_i);
    checkRegistered();
    bus.req_valid       = v;
    bus.req_sel         = SEL_W'(sel);
    bus.req_last        = last;
    bus.req_abort       = abort;
    bus.full            = full;
    bus.commit_id_valid = cv;
    bus.commit_id_value = ID_W'(cval);
    #1;
    ready_exp = !full && !abort && (m_open || (outstanding.size() < DEPTH));
    checkOutput("req_ready", int'(bus.req_ready), int'(ready_exp));
    checkOutput("commit_id_pull", int'(bus.commit_id_pull), int'(cv));
    accept   = v && ready_exp;
    e_idpush = 1'b0;
    e_push   = 1'b0;
    e_break  = 1'b0;
    e_update = 1'b0;
    e_rv     = 1'b0;
    if (cv) begin
      e_rv  = 1'b1;
      e_rid = cval;
      if (ID_CHECK && (cval != m_retire_ptr)) m_err = 1'b1;
      m_retire_ptr = (m_retire_ptr + 1) % DEPTH;
      if (outstanding.size() > 0) void'(outstanding.pop_front());
    end
    if (accept) begin
      if (!m_open) begin
        e_idpush = 1'b1;
        e_idval  = m_next_id;
        outstanding.push_back(m_next_id);
        m_next_id = (m_next_id + 1) % DEPTH;
      end
      e_push = 1'b1;
      e_sel  = sel;
      m_cnt++;
      if (last || (m_cnt == MAX_OPS)) begin
        e_break = 1'b1;
        m_cnt   = 0;
        m_open  = 1'b0;
      end else begin
        e_break = 1'b0;
        m_open  = 1'b1;
      end
    end else if (abort && m_open) begin
      e_update = 1'b1;
      m_open   = 1'b0;
      m_cnt    = 0;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic randomTraffic(input int cycles, input int commit_pct);
    bit v, last, abort, full, cv;
    int sel, cval;
    for (int i = 0; i < cycles; i++) begin
      v     = ($urandom_range(0, 99) < 70);
      sel   = int'($urandom_range(0, NUM_QUEUES - 1));
      last  = ($urandom_range(0, 99) < 35);
      full  = ($urandom_range(0, 99) < 15);
      abort = !full && ($urandom_range(0, 99) < 6);
      cv    = (outstanding.size() > 0) && ($urandom_range(0, 99) < commit_pct);
      cval  = cv ? outstanding[0] : 0;
      applyStimulus(v, sel, last, abort, full, cv, cval);
    end
  endtask

  initial begin
    driveIdleInputs();
    clearModel();

    // Single closing op
    resetDut();
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idleCycles(2);

    // Three-op transaction followed by a second transaction
    resetDut();
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idleCycles(2);

    // Forced close at MAX_OPS
    resetDut();
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, i % NUM_QUEUES, (i == 10), 1'b0, 1'b0, 1'b0, 0);
    idleCycles(2);

    // Abort of an open transaction, valid held high during the abort
    resetDut();
    applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idleCycles(2);

    // Back-pressure from full_i
    resetDut();
    applyStimulus(1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idleCycles(1);

    // Fill the ID pool, then free one ID and see allocation wrap to 0
    resetDut();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i % NUM_QUEUES, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idleCycles(2);

`ifdef DISPATCH_ID_CHECK_EN
    // Out-of-order commit sets the sticky error until reset
    resetDut();
    applyStimulus(1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
    idleCycles(4);
`endif

    // Randomized traffic: balanced, then commit-starved to reach pool exhaustion
    resetDut();
    randomTraffic(1500, 45);
    randomTraffic(500, 4);
    randomTraffic(800, 50);

    @(negedge clk_i);
    checkRegistered();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
